// File: rtl/fb_write_arbiter.sv
// Frame-buffer write arbiter: round-robin blue/red trail writes plus an optional
// full-frame clear engine (enabled by defining FBA_CLEAR_EN).
module fb_write_arbiter #(
  parameter logic [3:0] BLUE_COLOR = 4'h6,
  parameter logic [3:0] RED_COLOR  = 4'h4,
  parameter logic [3:0] BG_COLOR   = 4'h8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clear_start,
  input  logic        blue_req,
  input  logic [9:0]  blue_x,
  input  logic [9:0]  blue_y,
  input  logic        red_req,
  input  logic [9:0]  red_x,
  input  logic [9:0]  red_y,
  output logic        blue_ack,
  output logic        red_ack,
  output logic        WE,
  output logic [18:0] write_address,
  output logic [15:0] Data_In,
  output logic        busy,
  output logic        clear_done
);

  localparam logic [9:0]  H_RES     = 10'd640;
  localparam logic [9:0]  V_RES     = 10'd480;
  localparam logic [18:0] LAST_ADDR = 19'd153599;

  // Two 4-bit pixels per 16-bit word; upper nibble of each byte unused.
  function automatic logic [15:0] pixel_word(input logic [3:0] color);
    return {4'h0, color, 4'h0, color};
  endfunction

  // y*320 as shift-add so no multiplier is inferred.
  function automatic logic [18:0] pixel_addr(input logic [9:0] x, input logic [9:0] y);
    logic [18:0] y_w;
    y_w = {9'd0, y};
    return (y_w << 8) + (y_w << 6) + {10'd0, x[9:1]};
  endfunction

  function automatic logic on_screen(input logic [9:0] x, input logic [9:0] y);
    return (x < H_RES) && (y < V_RES);
  endfunction

`ifdef FBA_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_next;
`endif

  logic        prio_red, prio_red_next;   // 1: red wins a tie
  logic        blue_ack_next, red_ack_next, we_next, busy_next, done_next;
  logic [18:0] addr_next;
  logic [15:0] data_next;
  logic        blue_valid, red_valid, grant_blue, grant_red, arb_en;

  // A requester still seeing its ack this cycle has already been served.
  assign blue_valid = blue_req && !blue_ack;
  assign red_valid  = red_req  && !red_ack;
  assign grant_blue = blue_valid && (!red_valid || !prio_red);
  assign grant_red  = red_valid && !grant_blue;

`ifdef FBA_CLEAR_EN
  assign arb_en = (state == IDLE) && !clear_start;
`else
  assign arb_en = 1'b1;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    prio_red_next = prio_red;
    blue_ack_next = 1'b0;
    red_ack_next  = 1'b0;
    we_next       = 1'b0;
    addr_next     = write_address;
    data_next     = Data_In;
    busy_next     = 1'b0;
    done_next     = 1'b0;
`ifdef FBA_CLEAR_EN
    state_next    = state;
`endif

    if (arb_en) begin
      if (grant_blue) begin
        blue_ack_next = 1'b1;
        prio_red_next = 1'b1;
        if (on_screen(blue_x, blue_y)) begin
          we_next   = 1'b1;
          addr_next = pixel_addr(blue_x, blue_y);
          data_next = pixel_word(BLUE_COLOR);
        end
      end else if (grant_red) begin
        red_ack_next  = 1'b1;
        prio_red_next = 1'b0;
        if (on_screen(red_x, red_y)) begin
          we_next   = 1'b1;
          addr_next = pixel_addr(red_x, red_y);
          data_next = pixel_word(RED_COLOR);
        end
      end
    end

`ifdef FBA_CLEAR_EN
    if (state == IDLE && clear_start) begin
      state_next = CLEAR;
      we_next    = 1'b1;
      addr_next  = '0;
      data_next  = pixel_word(BG_COLOR);
      busy_next  = 1'b1;
    end else if (state == CLEAR) begin
      if (write_address == LAST_ADDR) begin
        // Final word already on the bus; hand back to arbitration next cycle.
        state_next = IDLE;
        done_next  = 1'b1;
      end else begin
        we_next   = 1'b1;
        addr_next = write_address + 19'd1;
        data_next = pixel_word(BG_COLOR);
        busy_next = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
`ifdef FBA_CLEAR_EN
      state         <= IDLE;
`endif
      prio_red      <= 1'b0;
      blue_ack      <= 1'b0;
      red_ack       <= 1'b0;
      WE            <= 1'b0;
      write_address <= '0;
      Data_In       <= '0;
      busy          <= 1'b0;
      clear_done    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
`ifdef FBA_CLEAR_EN
      state         <= state_next;
`endif
      prio_red      <= prio_red_next;
      blue_ack      <= blue_ack_next;
      red_ack       <= red_ack_next;
      WE            <= we_next;
      write_address <= addr_next;
      Data_In       <= data_next;
      busy          <= busy_next;
      clear_done    <= done_next;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed self-checking bench for fb_write_arbiter; the clear tests follow
// whether FBA_CLEAR_EN is defined for the build.
module tb_fb_write_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        clear_start = 1'b0;
  logic        blue_req = 1'b0, red_req = 1'b0;
  logic [9:0]  blue_x = '0, blue_y = '0, red_x = '0, red_y = '0;
  logic        blue_ack, red_ack, WE, busy, clear_done;
  logic [18:0] write_address;
  logic [15:0] Data_In;

  int n_cmp = 0;
  int n_err = 0;

  fb_write_arbiter dut (
    .Clk(Clk), .Reset(Reset), .clear_start(clear_start),
    .blue_req(blue_req), .blue_x(blue_x), .blue_y(blue_y),
    .red_req(red_req), .red_x(red_x), .red_y(red_y),
    .blue_ack(blue_ack), .red_ack(red_ack), .WE(WE),
    .write_address(write_address), .Data_In(Data_In),
    .busy(busy), .clear_done(clear_done)
  );

  always #5 Clk = ~Clk;

  // Advance one clock and settle past the edge before looking at outputs.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    blue_req = 1'b0; red_req = 1'b0; clear_start = 1'b0;
    step(); step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({blue_ack, red_ack, WE} !== 3'b000) begin n_err++; $display("FAIL reset_ack_we: got %b want 000", {blue_ack, red_ack, WE}); end
    n_cmp++; if (write_address !== 19'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", write_address); end
    n_cmp++; if (Data_In !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h want 0000", Data_In); end
    n_cmp++; if ({busy, clear_done} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done: got %b want 00", {busy, clear_done}); end
  endtask

  task automatic test_single_blue();
    do_reset();
    blue_req = 1'b1; blue_x = 10'd100; blue_y = 10'd10;
    step();
    n_cmp++; if ({blue_ack, red_ack, WE} !== 3'b101) begin n_err++; $display("FAIL blue_ack_we: got %b want 101", {blue_ack, red_ack, WE}); end
    n_cmp++; if (write_address !== 19'd3250) begin n_err++; $display("FAIL blue_addr: got %0d want 3250", write_address); end
    n_cmp++; if (Data_In !== 16'h0606) begin n_err++; $display("FAIL blue_data: got %h want 0606", Data_In); end
    blue_req = 1'b0;
    step();
    n_cmp++; if ({blue_ack, WE} !== 2'b00) begin n_err++; $display("FAIL blue_idle: got %b want 00", {blue_ack, WE}); end
    n_cmp++; if (write_address !== 19'd3250 || Data_In !== 16'h0606) begin n_err++; $display("FAIL blue_hold: got %0d/%h want 3250/0606", write_address, Data_In); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_ack;
    logic [18:0] exp_addr;
    logic [15:0] exp_data;
    do_reset();
    blue_req = 1'b1; blue_x = 10'd100; blue_y = 10'd10;
    red_req  = 1'b1; red_x  = 10'd2;   red_y  = 10'd0;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_ack  = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_addr = (i % 2 == 0) ? 19'd3250 : 19'd1;
      exp_data = (i % 2 == 0) ? 16'h0606 : 16'h0404;
      n_cmp++; if ({blue_ack, red_ack} !== exp_ack || WE !== 1'b1) begin n_err++; $display("FAIL rr_ack[%0d]: got %b we=%b want %b we=1", i, {blue_ack, red_ack}, WE, exp_ack); end
      n_cmp++; if (write_address !== exp_addr || Data_In !== exp_data) begin n_err++; $display("FAIL rr_word[%0d]: got %0d/%h want %0d/%h", i, write_address, Data_In, exp_addr, exp_data); end
    end
    blue_req = 1'b0; red_req = 1'b0;
    step();
  endtask

  task automatic test_pointer();
    do_reset();
    blue_req = 1'b1; blue_x = 10'd0; blue_y = 10'd0;
    step();
    blue_req = 1'b0;
    step();
    // Lone blue again: granted even though red now holds priority.
    blue_req = 1'b1;
    step();
    n_cmp++; if ({blue_ack, red_ack} !== 2'b10) begin n_err++; $display("FAIL ptr_single: got %b want 10", {blue_ack, red_ack}); end
    blue_req = 1'b0;
    step();
    blue_req = 1'b1; red_req = 1'b1; red_x = 10'd4; red_y = 10'd1;
    step();
    n_cmp++; if ({blue_ack, red_ack} !== 2'b01 || write_address !== 19'd322) begin n_err++; $display("FAIL ptr_tie: got %b addr %0d want 01 addr 322", {blue_ack, red_ack}, write_address); end
    blue_req = 1'b0; red_req = 1'b0;
    step();
  endtask

  task automatic test_boundary();
    do_reset();
    red_req = 1'b1; red_x = 10'd639; red_y = 10'd479;
    step();
    n_cmp++; if ({red_ack, WE} !== 2'b11 || write_address !== 19'd153599) begin n_err++; $display("FAIL edge_pixel: got ack/we %b addr %0d want 11 addr 153599", {red_ack, WE}, write_address); end
    n_cmp++; if (Data_In !== 16'h0404) begin n_err++; $display("FAIL edge_data: got %h want 0404", Data_In); end
    red_req = 1'b0;
    step();
    red_req = 1'b1; red_x = 10'd640; red_y = 10'd0;
    step();
    n_cmp++; if ({red_ack, WE} !== 2'b10) begin n_err++; $display("FAIL x_oob: got ack/we %b want 10", {red_ack, WE}); end
    n_cmp++; if (write_address !== 19'd153599) begin n_err++; $display("FAIL x_oob_hold: got %0d want 153599", write_address); end
    red_req = 1'b0;
    step();
    // Red was granted last (off-screen), so blue wins the tie.
    blue_req = 1'b1; blue_x = 10'd0; blue_y = 10'd480;
    red_req  = 1'b1; red_x  = 10'd8; red_y  = 10'd0;
    step();
    n_cmp++; if ({blue_ack, red_ack, WE} !== 3'b100) begin n_err++; $display("FAIL y_oob_ptr: got %b want 100", {blue_ack, red_ack, WE}); end
    blue_req = 1'b0;
    step();
    n_cmp++; if ({red_ack, WE} !== 2'b11 || write_address !== 19'd4) begin n_err++; $display("FAIL after_oob: got %b addr %0d want 11 addr 4", {red_ack, WE}, write_address); end
    red_req = 1'b0;
    step();
  endtask

`ifdef FBA_CLEAR_EN
  task automatic test_clear();
    do_reset();
    blue_req = 1'b1; blue_x = 10'd100; blue_y = 10'd10;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    n_cmp++; if ({WE, busy, blue_ack} !== 3'b110 || write_address !== 19'd0 || Data_In !== 16'h0808) begin n_err++; $display("FAIL clear_first: got we/busy/ack %b addr %0d data %h", {WE, busy, blue_ack}, write_address, Data_In); end
    for (int i = 1; i < 153600; i++) begin
      clear_start = (i == 100);
      step();
      n_cmp++;
      if ({WE, busy, blue_ack, clear_done} !== 4'b1100 || write_address !== 19'(i) || Data_In !== 16'h0808) begin
        n_err++; $display("FAIL clear_word[%0d]: got flags %b addr %0d data %h", i, {WE, busy, blue_ack, clear_done}, write_address, Data_In);
      end
    end
    step();
    n_cmp++; if ({clear_done, busy, WE, blue_ack} !== 4'b1000) begin n_err++; $display("FAIL clear_done: got %b want 1000", {clear_done, busy, WE, blue_ack}); end
    step();
    n_cmp++; if ({blue_ack, WE, clear_done} !== 3'b110 || write_address !== 19'd3250) begin n_err++; $display("FAIL post_clear_ack: got %b addr %0d", {blue_ack, WE, clear_done}, write_address); end
    blue_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 5000; i++) step();
    n_cmp++; if (write_address !== 19'd5000 || busy !== 1'b1) begin n_err++; $display("FAIL mid_clear_pos: got %0d busy %b want 5000 busy 1", write_address, busy); end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    n_cmp++; if ({WE, busy, clear_done} !== 3'b000 || write_address !== 19'd0) begin n_err++; $display("FAIL mid_clear_reset: got %b addr %0d", {WE, busy, clear_done}, write_address); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if ({WE, busy, clear_done} !== 3'b000) begin n_err++; $display("FAIL no_resume[%0d]: got %b want 000", i, {WE, busy, clear_done}); end
    end
  endtask
`else
  task automatic test_clear_disabled();
    do_reset();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    n_cmp++; if ({WE, busy, clear_done} !== 3'b000) begin n_err++; $display("FAIL noclear_pulse: got %b want 000", {WE, busy, clear_done}); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if ({WE, busy, clear_done} !== 3'b000) begin n_err++; $display("FAIL noclear_idle[%0d]: got %b want 000", i, {WE, busy, clear_done}); end
    end
    // Arbitration is unaffected by a stray clear_start.
    clear_start = 1'b1; blue_req = 1'b1; blue_x = 10'd100; blue_y = 10'd10;
    step();
    clear_start = 1'b0; blue_req = 1'b0;
    n_cmp++; if ({blue_ack, WE, busy} !== 3'b110 || write_address !== 19'd3250) begin n_err++; $display("FAIL noclear_arb: got %b addr %0d", {blue_ack, WE, busy}, write_address); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_blue();
    test_round_robin();
    test_pointer();
    test_boundary();
`ifdef FBA_CLEAR_EN
    test_clear();
    test_reset_mid_clear();
`else
    test_clear_disabled();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter BLUE_COLOR, default 4'h6, blue trail colour index.
REQ-002 Parameter RED_COLOR, default 4'h4, red trail colour index.
REQ-003 Parameter BG_COLOR, default 4'h8, background colour index used by clear.
REQ-004 Port Clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port Reset, input, 1, synchronous active-high reset.
REQ-006 Port clear_start, input, 1, single-cycle pulse requesting a full-frame clear.
REQ-007 Port blue_req, input, 1, blue trail write request; held until blue_ack.
REQ-008 Port blue_x / blue_y, input, 10 each, blue trail pixel coordinate.
REQ-009 Port red_req, input, 1, red trail write request; held until red_ack.
REQ-010 Port red_x / red_y, input, 10 each, red trail pixel coordinate.
REQ-011 Port blue_ack / red_ack, output, 1 each, one-cycle acceptance pulse.
REQ-012 Port WE, output, 1, frame buffer write enable.
REQ-013 Port write_address, output, 19, frame buffer word address.
REQ-014 Port Data_In, output, 16, frame buffer write word.
REQ-015 Port busy, output, 1, high while clear in progress.
REQ-016 Port clear_done, output, 1, one-cycle pulse on clear completion.

Function
REQ-017 States IDLE and CLEAR; IDLE->CLEAR on clear_start; CLEAR->IDLE after final word write.
REQ-018 Word format: colour index in [3:0] and [11:8], bits [7:4] and [15:12] zero; one write paints both pixels of the word.
REQ-019 Address = (x>>1) + y*320, computed as (y<<8)+(y<<6)+(x>>1), 19-bit result.
REQ-020 All outputs registered; request sampled in cycle N yields ack, WE, address and data together in cycle N+1.
REQ-021 At most one write per cycle; a requester whose ack is high in the current cycle is excluded from arbitration in that cycle.
REQ-022 Both requests valid: round-robin, grant goes to the requester not granted last; pointer starts at blue.
REQ-023 Single valid request: granted regardless of pointer; pointer updates to the granted requester.
REQ-024 Coordinate with x>=640 or y>=480: ack still pulses, WE stays 0, pointer updates.
REQ-025 CLEAR: write_address walks 0..153599 one per cycle, WE=1, data {4'h0,BG_COLOR,4'h0,BG_COLOR}; busy=1 from first clear write through final one.
REQ-026 clear_done pulses the cycle after address 153599 is written; IDLE arbitration resumes that same cycle.
REQ-027 During CLEAR: trail requests stall (no ack), clear_start ignored.
REQ-028 clear_start coincident with trail requests in IDLE: clear wins, requests stall.
REQ-029 WE=0 in any cycle without a grant or clear write; address/data hold last value.

Reset
REQ-030 Reset (sync, any state incl. mid-clear): state IDLE, WE=0, acks=0, busy=0, clear_done=0, write_address=0, Data_In=0, pointer=blue; aborted clear is not resumed.

Configuration
REQ-031 Macro FBA_CLEAR_EN defined: clear engine present per REQ-017..028.
REQ-032 FBA_CLEAR_EN undefined: no CLEAR state, clear_start ignored, busy and clear_done tied 0, arbitration unchanged.

Verification
REQ-033 Reset, blue_req=1 x=100 y=10 -> next cycle blue_ack=1, WE=1, address 3250, Data_In 16'h0606.
REQ-034 blue_req and red_req held high continuously -> acks alternate blue, red, blue, red; one WE per cycle.
REQ-035 red_req x=639 y=479 -> address 153599, Data_In 16'h0404; x=640 -> red_ack=1, WE=0.
REQ-036 clear_start with blue_req held -> 153600 consecutive BG writes (16'h0808), busy high, clear_done pulse, then blue_ack.
REQ-037 Reset asserted at clear word 5000 -> next cycle WE=0, busy=0, no clear_done; state IDLE.
REQ-038 Build without FBA_CLEAR_EN, clear_start pulse -> no writes, busy=0, clear_done=0.
